// File: rtl/snake_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | snake_pkg: shared direction codes, grid constants, FSM states    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package snake_pkg;

   localparam logic [1:0] DIR_RIGHT = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_UP    = 2'b10;
   localparam logic [1:0] DIR_LEFT  = 2'b11;

   localparam int DEF_GRID_W = 16;
   localparam int DEF_GRID_H = 12;
   localparam int CELL_SIZE  = 10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CALC  = 3'd1,
      ST_SCAN  = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4,
      ST_DEAD  = 3'd5
   } state_t;

   // The encoding pairs opposites as bitwise complements.
   function automatic logic [1:0] opposite(input logic [1:0] d);
      return ~d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/snake_head_stepper_dir_latch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dir_latch: prioritised button decode with reversal guard         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module dir_latch
   import snake_pkg::*;
(
   input  logic       CLOCK_50,
   input  logic       Resetn,
   input  logic       init_i,
   input  logic [3:0] key_i,
   input  logic [1:0] dir_i,
   output logic [1:0] pend_dir_o
);

   logic [1:0] pend_dir_q, pend_dir_d;
   logic [1:0] w_win;
   logic       w_any;

   always_comb begin
      w_any = 1'b1;
      w_win = DIR_RIGHT;
      if (!key_i[0])      w_win = DIR_RIGHT;
      else if (!key_i[1]) w_win = DIR_DOWN;
      else if (!key_i[2]) w_win = DIR_UP;
      else if (!key_i[3]) w_win = DIR_LEFT;
      else                w_any = 1'b0;

      pend_dir_d = pend_dir_q;
      if (w_any && (w_win != opposite(dir_i)))
         pend_dir_d = w_win;
   end

   always_ff @(posedge CLOCK_50) begin
      if (!Resetn || init_i)
         pend_dir_q <= DIR_RIGHT;
      else
         pend_dir_q <= pend_dir_d;
   end

   assign pend_dir_o = pend_dir_q;

endmodule
`default_nettype wire

// File: rtl/snake_head_stepper.sv
`default_nettype none
// +------------------------------------------------------------------+
// | snake_head_stepper: next-head calc, wall/self collision, apple   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module snake_head_stepper
   import snake_pkg::*;
#(
   parameter int GRID_W  = DEF_GRID_W,
   parameter int GRID_H  = DEF_GRID_H,
   parameter int MAX_LEN = 16,
   parameter int LW      = 5,
   localparam int IW     = $clog2(MAX_LEN)
) (
   input  logic          CLOCK_50,
   input  logic          Resetn,
   input  logic [3:0]    KEY,
   input  logic          init,
   input  logic          step,
   input  logic [LW-1:0] length,
   output logic [IW-1:0] seg_idx,
   input  logic [3:0]    seg_x,
   input  logic [3:0]    seg_y,
   input  logic [3:0]    apple_x,
   input  logic [3:0]    apple_y,
   output logic [3:0]    head_x,
   output logic [3:0]    head_y,
   output logic [1:0]    dir,
   output logic          busy,
   output logic          done,
   output logic          grow,
   output logic          dead
);

   localparam logic [3:0] C_START_X = 4'(GRID_W / 2);
   localparam logic [3:0] C_START_Y = 4'(GRID_H / 2);
   localparam logic [3:0] C_MAX_X   = 4'(GRID_W - 1);
   localparam logic [3:0] C_MAX_Y   = 4'(GRID_H - 1);

   state_t        state_q, state_d;
   logic [3:0]    head_x_q, head_x_d, head_y_q, head_y_d;
   logic [1:0]    dir_q, dir_d;
   logic          dead_q, dead_d, done_q, done_d, grow_q, grow_d;
   logic [IW-1:0] seg_idx_q, seg_idx_d;
   logic [LW-1:0] len_q, len_d;
   logic          issue_q, issue_d, cmp_q, cmp_d, last_q, last_d;

   logic [1:0]    w_pend_dir;
   logic [3:0]    w_nx, w_ny;
   logic          w_wall, w_hit, w_at_last;
   logic [LW-1:0] w_len_eff;

   dir_latch u_dir_latch (
      .CLOCK_50   (CLOCK_50),
      .Resetn     (Resetn),
      .init_i     (init),
      .key_i      (KEY),
      .dir_i      (dir_q),
      .pend_dir_o (w_pend_dir)
   );

   // Next cell is only computed off the wall, so the 4-bit add never wraps.
   always_comb begin
      w_wall = 1'b0;
      w_nx   = head_x_q;
      w_ny   = head_y_q;
      case (dir_q)
         DIR_RIGHT: if (head_x_q == C_MAX_X) w_wall = 1'b1; else w_nx = head_x_q + 4'd1;
         DIR_DOWN:  if (head_y_q == C_MAX_Y) w_wall = 1'b1; else w_ny = head_y_q + 4'd1;
         DIR_UP:    if (head_y_q == 4'd0)    w_wall = 1'b1; else w_ny = head_y_q - 4'd1;
         default:   if (head_x_q == 4'd0)    w_wall = 1'b1; else w_nx = head_x_q - 4'd1;
      endcase
   end

   assign w_len_eff = ((length == '0) || (length > LW'(MAX_LEN))) ? LW'(1) : length;
   assign w_hit     = (seg_x == w_nx) && (seg_y == w_ny);
   assign w_at_last = (LW'(seg_idx_q) == (len_q - LW'(2)));

   always_comb begin
      state_d   = state_q;
      head_x_d  = head_x_q;
      head_y_d  = head_y_q;
      dir_d     = dir_q;
      dead_d    = dead_q;
      grow_d    = grow_q;
      seg_idx_d = seg_idx_q;
      len_d     = len_q;
      issue_d   = 1'b0;
      cmp_d     = 1'b0;
      last_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (step && !dead_q) begin
               state_d = ST_CALC;
               dir_d   = w_pend_dir;
            end
         end
         ST_CALC: begin
            len_d = w_len_eff;
            if (w_wall) begin
               state_d = ST_DEAD;
            end else begin
               seg_idx_d = '0;
               if (w_len_eff == LW'(1)) begin
                  state_d = ST_CHECK;
               end else begin
                  state_d = ST_SCAN;
                  issue_d = 1'b1;
               end
            end
         end
         ST_SCAN: begin
            // Reads run one cycle ahead of compares; the tail index is never issued.
            cmp_d  = issue_q;
            last_d = issue_q && w_at_last;
            if (issue_q && !w_at_last) begin
               seg_idx_d = seg_idx_q + IW'(1);
               issue_d   = 1'b1;
            end
            if (cmp_q && w_hit)
               state_d = ST_DEAD;
            else if (cmp_q && last_q)
               state_d = ST_CHECK;
         end
         ST_CHECK: begin
            grow_d   = (w_nx == apple_x) && (w_ny == apple_y);
            head_x_d = w_nx;
            head_y_d = w_ny;
            state_d  = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_DEAD;
      endcase

      if ((state_d == ST_DEAD) && (state_q != ST_DEAD)) begin
         dead_d = 1'b1;
         grow_d = 1'b0;
      end
      done_d = (state_d == ST_DONE) || ((state_d == ST_DEAD) && (state_q != ST_DEAD));

      if (init) begin
         state_d  = ST_IDLE;
         head_x_d = C_START_X;
         head_y_d = C_START_Y;
         dir_d    = DIR_RIGHT;
         dead_d   = 1'b0;
         done_d   = 1'b0;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) begin
         state_q   <= ST_IDLE;
         head_x_q  <= C_START_X;
         head_y_q  <= C_START_Y;
         dir_q     <= DIR_RIGHT;
         dead_q    <= 1'b0;
         done_q    <= 1'b0;
         grow_q    <= 1'b0;
         seg_idx_q <= '0;
         len_q     <= LW'(1);
         issue_q   <= 1'b0;
         cmp_q     <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         head_x_q  <= head_x_d;
         head_y_q  <= head_y_d;
         dir_q     <= dir_d;
         dead_q    <= dead_d;
         done_q    <= done_d;
         grow_q    <= grow_d;
         seg_idx_q <= seg_idx_d;
         len_q     <= len_d;
         issue_q   <= issue_d;
         cmp_q     <= cmp_d;
         last_q    <= last_d;
      end
   end

   assign seg_idx = seg_idx_q;
   assign head_x  = head_x_q;
   assign head_y  = head_y_q;
   assign dir     = dir_q;
   assign busy    = (state_q != ST_IDLE) && (state_q != ST_DEAD);
   assign done    = done_q;
   assign grow    = grow_q;
   assign dead    = dead_q;

endmodule
`default_nettype wire
